// File: rtl/sy_pkg.sv
// Shared types for the pipelined EXU ALU: opcode enums, pipeline entry and commit records.
package sy_pkg;

  // Widest datapath supported; record fields are sized to this and zero-extended for XLEN=32.
  localparam int XLEN_MAX    = 64;
  localparam int ROB_WTH     = 6;
  localparam int PHY_REG_WTH = 7;

  typedef enum logic {
    INSTR_NORMAL = 1'b0,
    INSTR_JBR    = 1'b1
  } instr_cls_e;

  typedef enum logic [3:0] {
    ALS_ADD, ALS_SUB, ALS_SLL, ALS_SRL, ALS_SRA,
    ALS_XOR, ALS_OR, ALS_AND,
    ALS_SEQ, ALS_SNE, ALS_SLT, ALS_SGE, ALS_SLTU, ALS_SGEU
  } als_opcode_e;

  typedef enum logic {
    JBR_BRANCH = 1'b0,
    JBR_JUMP   = 1'b1
  } jbr_opcode_e;

  typedef struct packed {
    logic                vld;
    logic [ROB_WTH-1:0]  rob_idx;
    logic [XLEN_MAX-1:0] true_npc;
    logic                br_taken;
  } alu_commit_t;

  // Commit record of the pipelined ALU: alu_commit_t extended with the mispredict flag.
  typedef struct packed {
    logic                vld;
    logic [ROB_WTH-1:0]  rob_idx;
    logic [XLEN_MAX-1:0] true_npc;
    logic                br_taken;
    logic                mispred;
  } alu_pipe_commit_t;

  typedef struct packed {
    logic [ROB_WTH-1:0]     rob_idx;
    logic [XLEN_MAX-1:0]    res;
    logic [XLEN_MAX-1:0]    true_npc;
    logic                   br_taken;
    logic                   mispred;
    logic                   rdst_en;
    logic [PHY_REG_WTH-1:0] rdst_idx;
  } alu_pipe_entry_t;

endpackage

// File: rtl/sy_alu_core.sv
// Combinational ALU core: integer result, resolved next PC and branch-mispredict flag.
module sy_alu_core
  import sy_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic              instr_cls_is_jbr,
  input  als_opcode_e       als_opcode,
  input  jbr_opcode_e       jbr_opcode,
  input  logic              is_32,
  input  logic              is_c,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [XLEN-1:0]   jbr_base,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   imm,
  input  logic [XLEN-1:0]   pred_npc,
  output logic [XLEN-1:0]   res,
  output logic [XLEN-1:0]   true_npc,
  output logic              br_taken,
  output logic              mispred
);

  localparam int SHW = $clog2(XLEN);

  logic [31:0]     a32, b32, r32;
  logic [XLEN-1:0] rfull;
  logic            word_op;
  logic            redirect;

  // Compute both the 32-bit word result and the full-width result, then select.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    a32     = rs1_data[31:0];
    b32     = rs2_data[31:0];
    r32     = '0;
    rfull   = '0;
    word_op = 1'b0;
    case (als_opcode)
      ALS_ADD:  begin r32 = a32 + b32;                            rfull = rs1_data + rs2_data;                                 word_op = 1'b1; end
      ALS_SUB:  begin r32 = a32 - b32;                            rfull = rs1_data - rs2_data;                                 word_op = 1'b1; end
      ALS_SLL:  begin r32 = a32 << b32[4:0];                      rfull = rs1_data << rs2_data[SHW-1:0];                       word_op = 1'b1; end
      ALS_SRL:  begin r32 = a32 >> b32[4:0];                      rfull = rs1_data >> rs2_data[SHW-1:0];                       word_op = 1'b1; end
      ALS_SRA:  begin r32 = 32'($signed(a32) >>> b32[4:0]);       rfull = XLEN'($signed(rs1_data) >>> rs2_data[SHW-1:0]);      word_op = 1'b1; end
      ALS_XOR:  rfull = rs1_data ^ rs2_data;
      ALS_OR:   rfull = rs1_data | rs2_data;
      ALS_AND:  rfull = rs1_data & rs2_data;
      ALS_SEQ:  rfull = XLEN'(rs1_data == rs2_data);
      ALS_SNE:  rfull = XLEN'(rs1_data != rs2_data);
      ALS_SLT:  rfull = XLEN'($signed(rs1_data) <  $signed(rs2_data));
      ALS_SGE:  rfull = XLEN'($signed(rs1_data) >= $signed(rs2_data));
      ALS_SLTU: rfull = XLEN'(rs1_data <  rs2_data);
      ALS_SGEU: rfull = XLEN'(rs1_data >= rs2_data);
      default:  rfull = '0;
    endcase
    // Word ops only exist on a 64-bit datapath; the 32-bit result is sign-extended from bit 31.
    if (word_op && is_32 && (XLEN == 64)) res = XLEN'($signed(r32));
    else                                  res = rfull;
  end

  // Jumps always redirect; branches redirect only when the compare result is true.
  assign redirect = instr_cls_is_jbr && !(jbr_opcode == JBR_BRANCH && !res[0]);
  assign true_npc = redirect ? (jbr_base + imm) : (pc + (is_c ? XLEN'(2) : XLEN'(4)));
  assign br_taken = res[0];
  assign mispred  = instr_cls_is_jbr && (true_npc != pred_npc);

endmodule

// File: rtl/sy_ppl_alu_pipe.sv
// Pipelined integer ALU: combinational core feeding PIPE_DEPTH elastic result stages with
// valid/ready backpressure from the GPR write port, flush, and commit/writeback/wakeup outputs.
module sy_ppl_alu_pipe
  import sy_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int PIPE_DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   alu_en_i,
  output logic                   alu_rdy_o,
  input  logic [ROB_WTH-1:0]     rob_idx_i,
  input  instr_cls_e             instr_cls_i,
  input  als_opcode_e            als_opcode_i,
  input  jbr_opcode_e            jbr_opcode_i,
  input  logic                   is_32_i,
  input  logic                   is_c_i,
  input  logic [XLEN-1:0]        rs1_data_i,
  input  logic [XLEN-1:0]        rs2_data_i,
  input  logic [XLEN-1:0]        jbr_base_i,
  input  logic [XLEN-1:0]        pc_i,
  input  logic [XLEN-1:0]        imm_i,
  input  logic [XLEN-1:0]        pred_npc_i,
  input  logic                   rdst_en_i,
  input  logic [PHY_REG_WTH-1:0] rdst_idx_i,
  input  logic                   wb_rdy_i,
  output alu_pipe_commit_t       alu_rob__commit_o,
  output logic                   alu_gpr__we_o,
  output logic [PHY_REG_WTH-1:0] alu_gpr__idx_o,
  output logic [XLEN-1:0]        alu_gpr__wdata_o,
  output logic                   alu_awake_vld_o,
  output logic [PHY_REG_WTH-1:0] alu_awake_idx_o
);

  logic [XLEN-1:0]       core_res, core_npc;
  logic                  core_taken, core_mispred;
  alu_pipe_entry_t       s0;
  alu_pipe_entry_t       tail;
  logic [PIPE_DEPTH-1:0] vld, adv, load;
  logic                  accept, last_vld, fire;

  sy_alu_core #(.XLEN(XLEN)) u_core (
    .instr_cls_is_jbr (instr_cls_i == INSTR_JBR),
    .als_opcode       (als_opcode_i),
    .jbr_opcode       (jbr_opcode_i),
    .is_32            (is_32_i),
    .is_c             (is_c_i),
    .rs1_data         (rs1_data_i),
    .rs2_data         (rs2_data_i),
    .jbr_base         (jbr_base_i),
    .pc               (pc_i),
    .imm              (imm_i),
    .pred_npc         (pred_npc_i),
    .res              (core_res),
    .true_npc         (core_npc),
    .br_taken         (core_taken),
    .mispred          (core_mispred)
  );

  // Pack the issued op and its computed result into a pipeline entry.
  always_comb begin
    s0          = '0;
    s0.rob_idx  = rob_idx_i;
    s0.res      = XLEN_MAX'(core_res);
    s0.true_npc = XLEN_MAX'(core_npc);
    s0.br_taken = core_taken;
    s0.mispred  = core_mispred;
    s0.rdst_en  = rdst_en_i;
    s0.rdst_idx = rdst_idx_i;
  end

  // A stage advances if the tail retires or any stage downstream of it is empty (bubbles collapse).
  always_comb begin
    logic go;
    adv = '0;
    go  = wb_rdy_i && !flush_i;
    for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
      adv[k] = vld[k] && go;
      go     = go || !vld[k];
    end
  end

  assign alu_rdy_o = !flush_i && (!vld[0] || adv[0]);
  assign accept    = alu_en_i && alu_rdy_o;
  // Stage k loads from stage k-1 when that one advances; stage 0 loads on accept.
  assign load      = PIPE_DEPTH'({adv, accept});

  // Valid bits: fill on load, drain on advance, cleared wholesale by flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    if (!rst_ni)      vld <= '0;
    else if (flush_i) vld <= '0;
    else              vld <= load | (vld & ~adv);
  end

  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
    alu_pipe_entry_t q;
    if (k == 0) begin : g_head
      // Capture the freshly computed entry on accept.
      // NOTE: payload registers carry no reset; the valid bits alone decide whether their contents matter.
      always_ff @(posedge clk_i) if (load[0]) q <= s0;
    end else begin : g_body
      // Shift the upstream entry in when it advances.
      always_ff @(posedge clk_i) if (load[k]) q <= g_stage[k-1].q;
    end
  end

  assign tail     = g_stage[PIPE_DEPTH-1].q;
  assign last_vld = vld[PIPE_DEPTH-1];
  assign fire     = last_vld && wb_rdy_i && !flush_i;

  // Commit record: pulse on retire, payload visible (and stable) whenever the tail holds an entry.
  always_comb begin
    alu_rob__commit_o     = '0;
    alu_rob__commit_o.vld = fire;
    if (last_vld) begin
      alu_rob__commit_o.rob_idx  = tail.rob_idx;
      alu_rob__commit_o.true_npc = tail.true_npc;
      alu_rob__commit_o.br_taken = tail.br_taken;
      alu_rob__commit_o.mispred  = tail.mispred;
    end
  end

  assign alu_gpr__we_o    = fire && tail.rdst_en;
  assign alu_gpr__idx_o   = last_vld ? tail.rdst_idx : '0;
  assign alu_gpr__wdata_o = last_vld ? tail.res[XLEN-1:0] : '0;
  assign alu_awake_vld_o  = alu_gpr__we_o;
  assign alu_awake_idx_o  = alu_gpr__idx_o;

endmodule

// File: tb/tb_sy_ppl_alu_pipe.sv
// Self-checking bench for sy_ppl_alu_pipe: directed vector table, randomized traffic against a
// queue-based reference model, and directed backpressure / flush / reset sequences.
module tb_sy_ppl_alu_pipe;
  import sy_pkg::*;

  localparam int XLEN = 64;
  localparam int D    = 2;

  typedef struct {
    instr_cls_e             cls;
    als_opcode_e            op;
    jbr_opcode_e            jop;
    bit                     w, c;
    logic [63:0]            rs1, rs2, base, pc, imm, pred;
    logic [ROB_WTH-1:0]     rob;
    bit                     rd_en;
    logic [PHY_REG_WTH-1:0] rd_idx;
  } stim_t;

  typedef struct {
    logic [ROB_WTH-1:0]     rob;
    logic [63:0]            res, npc;
    bit                     taken, mispred, rd_en;
    logic [PHY_REG_WTH-1:0] rd_idx;
  } exp_t;

  typedef struct {
    stim_t       s;
    logic [63:0] res, npc;
    bit          taken, mispred;
  } vec_t;

  logic clk_i, rst_ni, flush_i, alu_en_i, alu_rdy_o, wb_rdy_i;
  logic [ROB_WTH-1:0]     rob_idx_i;
  instr_cls_e             instr_cls_i;
  als_opcode_e            als_opcode_i;
  jbr_opcode_e            jbr_opcode_i;
  logic                   is_32_i, is_c_i, rdst_en_i;
  logic [XLEN-1:0]        rs1_data_i, rs2_data_i, jbr_base_i, pc_i, imm_i, pred_npc_i;
  logic [PHY_REG_WTH-1:0] rdst_idx_i;
  alu_pipe_commit_t       alu_rob__commit_o;
  logic                   alu_gpr__we_o, alu_awake_vld_o;
  logic [PHY_REG_WTH-1:0] alu_gpr__idx_o, alu_awake_idx_o;
  logic [XLEN-1:0]        alu_gpr__wdata_o;

  sy_ppl_alu_pipe #(.XLEN(XLEN), .PIPE_DEPTH(D)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .alu_en_i(alu_en_i), .alu_rdy_o(alu_rdy_o),
    .rob_idx_i(rob_idx_i), .instr_cls_i(instr_cls_i), .als_opcode_i(als_opcode_i),
    .jbr_opcode_i(jbr_opcode_i), .is_32_i(is_32_i), .is_c_i(is_c_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .jbr_base_i(jbr_base_i), .pc_i(pc_i),
    .imm_i(imm_i), .pred_npc_i(pred_npc_i), .rdst_en_i(rdst_en_i), .rdst_idx_i(rdst_idx_i),
    .wb_rdy_i(wb_rdy_i), .alu_rob__commit_o(alu_rob__commit_o), .alu_gpr__we_o(alu_gpr__we_o),
    .alu_gpr__idx_o(alu_gpr__idx_o), .alu_gpr__wdata_o(alu_gpr__wdata_o),
    .alu_awake_vld_o(alu_awake_vld_o), .alu_awake_idx_o(alu_awake_idx_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int          n_vec = 0;
  int          n_err = 0;
  exp_t        exp_q[$];
  vec_t        tbl[$];
  stim_t       cur;
  bit          last_acc, saw_commit, obs_rdy;
  logic [63:0] cap_wdata, cap_npc;
  logic [ROB_WTH-1:0] cap_rob;
  bit          cap_taken, cap_mis;

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: results derived directly from the ALU rules using plain integer types.
  function automatic exp_t model(stim_t s);
    exp_t        e;
    longint      sa, sb;
    int          sw, sh;
    int unsigned uw;
    logic [63:0] r;
    bit          word;
    sa   = longint'(s.rs1);
    sb   = longint'(s.rs2);
    r    = '0;
    word = s.w && (s.op inside {ALS_ADD, ALS_SUB, ALS_SLL, ALS_SRL, ALS_SRA});
    sh   = word ? int'(s.rs2 % 64'd32) : int'(s.rs2 % 64'd64);
    if (word) begin
      sw = int'(s.rs1[31:0]);
      uw = s.rs1[31:0];
      case (s.op)
        ALS_ADD: sw = sw + int'(s.rs2[31:0]);
        ALS_SUB: sw = sw - int'(s.rs2[31:0]);
        ALS_SLL: sw = sw << sh;
        ALS_SRL: sw = int'(uw >> sh);
        ALS_SRA: sw = sw >>> sh;
        default: ;
      endcase
      r = 64'(longint'(sw));
    end else begin
      case (s.op)
        ALS_ADD:  r = s.rs1 + s.rs2;
        ALS_SUB:  r = s.rs1 - s.rs2;
        ALS_SLL:  r = s.rs1 << sh;
        ALS_SRL:  r = s.rs1 >> sh;
        ALS_SRA:  r = 64'(sa >>> sh);
        ALS_XOR:  r = s.rs1 ^ s.rs2;
        ALS_OR:   r = s.rs1 | s.rs2;
        ALS_AND:  r = s.rs1 & s.rs2;
        ALS_SEQ:  r = 64'(s.rs1 == s.rs2);
        ALS_SNE:  r = 64'(s.rs1 != s.rs2);
        ALS_SLT:  r = 64'(sa < sb);
        ALS_SGE:  r = 64'(sa >= sb);
        ALS_SLTU: r = 64'(s.rs1 < s.rs2);
        ALS_SGEU: r = 64'(s.rs1 >= s.rs2);
        default:  r = '0;
      endcase
    end
    e.res     = r;
    e.taken   = r[0];
    if (s.cls == INSTR_JBR && (s.jop == JBR_JUMP || r[0])) e.npc = s.base + s.imm;
    else                                                   e.npc = s.pc + (s.c ? 64'd2 : 64'd4);
    e.mispred = (s.cls == INSTR_JBR) && (e.npc != s.pred);
    e.rob     = s.rob;
    e.rd_en   = s.rd_en;
    e.rd_idx  = s.rd_idx;
    return e;
  endfunction

  function automatic stim_t mk(als_opcode_e op, bit w, bit c, instr_cls_e cls, jbr_opcode_e jop,
                               logic [63:0] rs1, logic [63:0] rs2, logic [63:0] base,
                               logic [63:0] pc, logic [63:0] imm, logic [63:0] pred);
    stim_t s;
    s.op = op; s.w = w; s.c = c; s.cls = cls; s.jop = jop;
    s.rs1 = rs1; s.rs2 = rs2; s.base = base; s.pc = pc; s.imm = imm; s.pred = pred;
    s.rob = '0; s.rd_en = 1'b1; s.rd_idx = '0;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t       s;
    logic [63:0] v[6];
    for (int k = 0; k < 6; k++) begin
      case ($urandom_range(0, 3))
        0:       v[k] = 64'($urandom_range(0, 3));
        1:       v[k] = '1;
        default: v[k] = {$urandom, $urandom};
      endcase
    end
    s = mk(als_opcode_e'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           instr_cls_e'($urandom_range(0, 1)), jbr_opcode_e'($urandom_range(0, 1)),
           v[0], v[1], v[2], v[3] & ~64'd1, v[4], v[5]);
    if ($urandom_range(0, 1) == 1) s.pred = s.base + s.imm;
    s.rd_en  = ($urandom_range(0, 3) != 0);
    s.rd_idx = PHY_REG_WTH'($urandom);
    return s;
  endfunction

  task automatic add(stim_t s, logic [63:0] res, logic [63:0] npc, bit taken, bit mis);
    vec_t v;
    v.s = s; v.res = res; v.npc = npc; v.taken = taken; v.mispred = mis;
    tbl.push_back(v);
  endtask

  task automatic drive(stim_t s, bit en);
    cur          = s;
    alu_en_i     = en;
    instr_cls_i  = s.cls;  als_opcode_i = s.op;  jbr_opcode_i = s.jop;
    is_32_i      = s.w;    is_c_i       = s.c;
    rs1_data_i   = s.rs1;  rs2_data_i   = s.rs2; jbr_base_i   = s.base;
    pc_i         = s.pc;   imm_i        = s.imm; pred_npc_i   = s.pred;
    rob_idx_i    = s.rob;  rdst_en_i    = s.rd_en; rdst_idx_i = s.rd_idx;
  endtask

  // One clock: observe outputs mid-cycle, score commits against the model queue, record accepts.
  task automatic cycle();
    exp_t e;
    #2;
    last_acc   = 1'b0;
    saw_commit = 1'b0;
    obs_rdy    = alu_rdy_o;
    if (!rst_ni) begin
      check("rst_rdy",    64'(alu_rdy_o), 64'd1);
      check("rst_commit", 64'(alu_rob__commit_o), 64'd0);
      check("rst_we",     64'(alu_gpr__we_o), 64'd0);
      check("rst_idx",    64'(alu_gpr__idx_o), 64'd0);
      check("rst_wdata",  alu_gpr__wdata_o, 64'd0);
      check("rst_awake",  64'(alu_awake_vld_o), 64'd0);
      exp_q.delete();
    end else begin
      if (alu_rob__commit_o.vld) begin
        saw_commit = 1'b1;
        cap_wdata  = alu_gpr__wdata_o;
        cap_npc    = alu_rob__commit_o.true_npc;
        cap_taken  = alu_rob__commit_o.br_taken;
        cap_mis    = alu_rob__commit_o.mispred;
        cap_rob    = alu_rob__commit_o.rob_idx;
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_commit: rob %0d committed with nothing in flight (t=%0t)",
                   alu_rob__commit_o.rob_idx, $time);
        end else begin
          e = exp_q.pop_front();
          check("commit_rob",   64'(alu_rob__commit_o.rob_idx), 64'(e.rob));
          check("gpr_wdata",    alu_gpr__wdata_o, e.res);
          check("commit_npc",   alu_rob__commit_o.true_npc, e.npc);
          check("commit_taken", 64'(alu_rob__commit_o.br_taken), 64'(e.taken));
          check("commit_mis",   64'(alu_rob__commit_o.mispred), 64'(e.mispred));
          check("gpr_we",       64'(alu_gpr__we_o), 64'(e.rd_en));
          check("gpr_idx",      64'(alu_gpr__idx_o), 64'(e.rd_idx));
          check("awake_vld",    64'(alu_awake_vld_o), 64'(e.rd_en));
          check("awake_idx",    64'(alu_awake_idx_o), 64'(e.rd_idx));
        end
      end else begin
        check("idle_we",    64'(alu_gpr__we_o), 64'd0);
        check("idle_awake", 64'(alu_awake_vld_o), 64'd0);
      end
      if (flush_i) begin
        check("flush_rdy",    64'(alu_rdy_o), 64'd0);
        check("flush_commit", 64'(alu_rob__commit_o.vld), 64'd0);
        check("flush_we",     64'(alu_gpr__we_o), 64'd0);
        exp_q.delete();
      end else if (alu_en_i && alu_rdy_o) begin
        last_acc = 1'b1;
        exp_q.push_back(model(cur));
      end
    end
    @(negedge clk_i);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    stim_t s, idle;
    stim_t bp[4];
    int    lat, i, commits, first_stall;
    logic [7:0] tag;

    // Directed vector table: {stimulus, expected result, npc, taken, mispred}.
    add(mk(ALS_ADD, 0, 0, INSTR_NORMAL, JBR_BRANCH, '1, 64'd1, 0, 64'h100, 0, 0),
        64'h0, 64'h104, 0, 0);
    add(mk(ALS_ADD, 1, 0, INSTR_NORMAL, JBR_BRANCH, 64'h7FFF_FFFF, 64'd1, 0, 64'h100, 0, 0),
        64'hFFFF_FFFF_8000_0000, 64'h104, 0, 0);
    add(mk(ALS_SRA, 1, 0, INSTR_NORMAL, JBR_BRANCH, 64'h8000_0000, 64'h21, 0, 64'h100, 0, 0),
        64'hFFFF_FFFF_C000_0000, 64'h104, 0, 0);
    add(mk(ALS_SLL, 0, 0, INSTR_NORMAL, JBR_BRANCH, 64'h8000_0000_0000_0001, 64'h41, 0, 64'h100, 0, 0),
        64'h2, 64'h104, 0, 0);
    add(mk(ALS_SLT, 0, 0, INSTR_JBR, JBR_BRANCH, '1, 64'd1, 64'h1000, 64'h1000, 64'h20, 64'h1004),
        64'h1, 64'h1020, 1, 1);
    add(mk(ALS_SLT, 0, 0, INSTR_JBR, JBR_BRANCH, '1, 64'd1, 64'h1000, 64'h1000, 64'h20, 64'h1020),
        64'h1, 64'h1020, 1, 0);
    add(mk(ALS_SGE, 0, 0, INSTR_JBR, JBR_BRANCH, '1, 64'd1, 64'h1000, 64'h1000, 64'h20, 64'h1004),
        64'h0, 64'h1004, 0, 0);
    add(mk(ALS_ADD, 0, 1, INSTR_JBR, JBR_JUMP, 64'h2000, 64'd0, 64'h3000, 64'h500, 64'h10, 64'h502),
        64'h2000, 64'h3010, 0, 1);
    add(mk(ALS_SUB, 0, 1, INSTR_NORMAL, JBR_BRANCH, 64'd0, 64'd1, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0),
        '1, 64'h0, 1, 0);
    add(mk(ALS_SLTU, 0, 0, INSTR_NORMAL, JBR_BRANCH, 64'd1, '1, 0, 64'h100, 0, 0),
        64'h1, 64'h104, 1, 0);
    add(mk(ALS_SRA, 0, 0, INSTR_NORMAL, JBR_BRANCH, 64'h8000_0000_0000_0000, 64'h3F, 0, 64'h100, 0, 0),
        '1, 64'h104, 1, 0);
    add(mk(ALS_XOR, 0, 0, INSTR_NORMAL, JBR_BRANCH, 64'hF0F0, 64'hFF00, 0, 64'h100, 0, 0),
        64'h0FF0, 64'h104, 0, 0);
    add(mk(ALS_SRL, 1, 0, INSTR_NORMAL, JBR_BRANCH, 64'hFFFF_FFFF_8000_0000, 64'd31, 0, 64'h100, 0, 0),
        64'h1, 64'h104, 1, 0);
    add(mk(ALS_SEQ, 0, 0, INSTR_NORMAL, JBR_BRANCH, 64'd5, 64'd5, 0, 64'h100, 0, 0),
        64'h1, 64'h104, 1, 0);
    add(mk(als_opcode_e'(15), 0, 0, INSTR_NORMAL, JBR_BRANCH, 64'd5, 64'd9, 0, 64'h100, 0, 0),
        64'h0, 64'h104, 0, 0);
    add(mk(ALS_SGEU, 0, 1, INSTR_JBR, JBR_BRANCH, 64'd3, 64'd3, 64'h4000, 64'h4000, 64'hFFFF_FFFF_FFFF_FFF8, 64'h3FF8),
        64'h1, 64'h3FF8, 1, 0);

    idle = mk(ALS_ADD, 0, 0, INSTR_NORMAL, JBR_BRANCH, 0, 0, 0, 0, 0, 0);
    rst_ni = 1'b0; flush_i = 1'b0; wb_rdy_i = 1'b1;
    drive(idle, 1'b0);
    @(negedge clk_i);
    cycle(); cycle();
    rst_ni = 1'b1;
    cycle();
    check("init_rdy", 64'(obs_rdy), 64'd1);

    // Table vectors: one op at a time, checking latency and the fixed expected values.
    for (int v = 0; v < tbl.size(); v++) begin
      s        = tbl[v].s;
      s.rob    = ROB_WTH'(v);
      s.rd_idx = PHY_REG_WTH'(v + 3);
      s.rd_en  = (v % 5 != 4);
      drive(s, 1'b1);
      cycle();
      check("tbl_accept", 64'(last_acc), 64'd1);
      drive(s, 1'b0);
      lat = 0;
      do begin cycle(); lat++; end while (!saw_commit && lat < 10);
      check("tbl_latency", 64'(lat), 64'(D));
      check("tbl_res",     cap_wdata, tbl[v].res);
      check("tbl_npc",     cap_npc, tbl[v].npc);
      check("tbl_taken",   64'(cap_taken), 64'(tbl[v].taken));
      check("tbl_mispred", 64'(cap_mis), 64'(tbl[v].mispred));
    end

    // Backpressure: 4 back-to-back ops with wb_rdy low for the first 5 cycles.
    for (int k = 0; k < 4; k++) begin
      bp[k] = mk(ALS_ADD, 0, 0, INSTR_NORMAL, JBR_BRANCH, 64'(k * 100), 64'd7, 0, 64'(32'h2000 + k * 4), 0, 0);
      bp[k].rob    = ROB_WTH'(40 + k);
      bp[k].rd_idx = PHY_REG_WTH'(20 + k);
    end
    i = 0; commits = 0; first_stall = -1;
    for (int t = 0; t < 40 && !(i == 4 && exp_q.size() == 0); t++) begin
      wb_rdy_i = (t >= 5);
      drive(bp[i < 4 ? i : 3], i < 4);
      cycle();
      if (saw_commit) commits++;
      if (t < 5 && !obs_rdy && first_stall < 0) begin
        first_stall = t;
        check("bp_accepts_before_stall", 64'(i), 64'(D));
      end
      if (last_acc) i++;
      if (t >= 2 && t < 5 && exp_q.size() > 0) begin
        check("bp_hold_wdata",  alu_gpr__wdata_o, exp_q[0].res);
        check("bp_hold_commit", 64'(alu_rob__commit_o.vld), 64'd0);
        check("bp_hold_rob",    64'(alu_rob__commit_o.rob_idx), 64'(exp_q[0].rob));
      end
    end
    check("bp_stall_seen",  64'(first_stall >= 0), 64'd1);
    check("bp_commits",     64'(commits), 64'd4);
    check("bp_all_issued",  64'(i), 64'd4);

    // Flush: in-flight ops and the op presented with the flush never retire.
    wb_rdy_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s = bp[k]; s.rob = ROB_WTH'(50 + k);
      drive(s, 1'b1);
      cycle();
    end
    flush_i = 1'b1; wb_rdy_i = 1'b1;
    s = bp[3]; s.rob = ROB_WTH'(53);
    drive(s, 1'b1);
    cycle();
    flush_i = 1'b0;
    s = tbl[4].s; s.rob = ROB_WTH'(60); s.rd_idx = PHY_REG_WTH'(9);
    drive(s, 1'b1);
    cycle();
    check("fresh_accept", 64'(last_acc), 64'd1);
    drive(s, 1'b0);
    lat = 0;
    do begin cycle(); lat++; end while (!saw_commit && lat < 10);
    check("fresh_latency", 64'(lat), 64'(D));
    check("fresh_rob",     64'(cap_rob), 64'd60);
    for (int k = 0; k < 4; k++) cycle();

    // Randomized traffic with random backpressure and occasional flushes.
    tag = 8'd0;
    for (int n = 0; n < 500; n++) begin
      s        = rand_stim();
      s.rob    = ROB_WTH'(tag);
      tag      = tag + 8'd1;
      wb_rdy_i = ($urandom_range(0, 9) < 7);
      flush_i  = ($urandom_range(0, 29) == 0);
      drive(s, $urandom_range(0, 3) != 0);
      cycle();
    end
    flush_i = 1'b0; wb_rdy_i = 1'b1;
    drive(idle, 1'b0);
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) cycle();
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    // Reset mid-stream: immediate idle outputs, no stale commit afterwards.
    for (int k = 0; k < 3; k++) begin
      s = rand_stim(); s.rob = ROB_WTH'(k);
      drive(s, 1'b1);
      cycle();
    end
    rst_ni = 1'b0;
    drive(idle, 1'b0);
    cycle(); cycle();
    rst_ni = 1'b1;
    cycle();
    check("post_rst_rdy", 64'(obs_rdy), 64'd1);
    for (int k = 0; k < 6; k++) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
